// File: rtl/mul8_share_arb_if.sv
// Operand request and product response channels shared between the
// operand sources and the round-robin multiplier scheduler.
interface mul8_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/mul8_share_arb.sv
// Round-robin scheduler time-sharing one external combinational 8x8
// multiplier among NREQ requesters through a two-stage pipeline.
module mul8_share_arb #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int ZERO_FORCE = 1,
    parameter int CNTW       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul8_share_arb_if.slave      bus,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_o,
    output logic [CNTW-1:0]      op_count
);

    function automatic logic has_zero_operand(input logic [7:0] a, input logic [7:0] b);
        return (a == 8'h00) || (b == 8'h00);
    endfunction

    // Approximate netlists may return nonzero for a zero operand; override it.
    function automatic logic [15:0] select_product(input logic zero_flag, input logic [15:0] raw);
        return ((ZERO_FORCE != 0) && zero_flag) ? 16'h0000 : raw;
    endfunction

    logic                 s1_valid_r;
    logic                 zero_r;
    logic [7:0]           op_a_r;
    logic [7:0]           op_b_r;
    logic [IDW-1:0]       s1_id_r;
    logic [IDW-1:0]       ptr_r;
    logic                 rsp_valid_r;
    logic [IDW-1:0]       rsp_id_r;
    logic [15:0]          rsp_prod_r;
    logic [CNTW-1:0]      op_count_r;

    logic                 s2_free_s;
    logic                 s1_free_s;
    logic                 hi_found_s;
    logic                 lo_found_s;
    logic [IDW-1:0]       hi_id_s;
    logic [IDW-1:0]       lo_id_s;
    logic [IDW-1:0]       grant_id_s;
    logic [NREQ-1:0]      grant_vec_s;
    logic                 accept_s;
    logic [IDW-1:0]       ptr_next_s;
    logic [7:0]           acc_a_s;
    logic [7:0]           acc_b_s;

    assign s2_free_s = !rsp_valid_r || bus.rsp_ready;
    assign s1_free_s = !s1_valid_r || s2_free_s;

    // Round-robin search: lowest valid index at or above the pointer wins,
    // otherwise the search wraps to the lowest valid index overall.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = {IDW{1'b0}};
        lo_id_s    = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            hi_id_s    = (bus.req_valid[i] && (IDW'(i) >= ptr_r)) ? IDW'(i) : hi_id_s;
            hi_found_s = hi_found_s || (bus.req_valid[i] && (IDW'(i) >= ptr_r));
            lo_id_s    = bus.req_valid[i] ? IDW'(i) : lo_id_s;
            lo_found_s = lo_found_s || bus.req_valid[i];
        end
    end

    assign grant_id_s  = hi_found_s ? hi_id_s : lo_id_s;
    assign grant_vec_s = (rst_n && s1_free_s && lo_found_s)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_s)
                         : {NREQ{1'b0}};
    assign accept_s    = |(bus.req_valid & grant_vec_s);
    assign ptr_next_s  = (grant_id_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (grant_id_s + IDW'(1));

    // Operand mux for the granted requester.
    always_comb begin
        acc_a_s = 8'h00;
        acc_b_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            acc_a_s = (grant_id_s == IDW'(i)) ? bus.req_a[8*i +: 8] : acc_a_s;
            acc_b_s = (grant_id_s == IDW'(i)) ? bus.req_b[8*i +: 8] : acc_b_s;
        end
    end

    // Stage 1: operand registers feeding the multiplier, plus pointer and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            zero_r     <= 1'b0;
            op_a_r     <= 8'h00;
            op_b_r     <= 8'h00;
            s1_id_r    <= {IDW{1'b0}};
            ptr_r      <= {IDW{1'b0}};
            op_count_r <= {CNTW{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            zero_r     <= has_zero_operand(acc_a_s, acc_b_s);
            op_a_r     <= acc_a_s;
            op_b_r     <= acc_b_s;
            s1_id_r    <= grant_id_s;
            ptr_r      <= ptr_next_s;
            op_count_r <= op_count_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else if (s1_valid_r && s2_free_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: response register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_prod_r  <= 16'h0000;
        end else if (s1_valid_r && s2_free_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= s1_id_r;
            rsp_prod_r  <= select_product(zero_r, mul_o);
        end else if (s2_free_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign mul_a         = op_a_r;
    assign mul_b         = op_b_r;
    assign op_count      = op_count_r;
    assign bus.req_ready = grant_vec_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_prod  = rsp_prod_r;

endmodule

// File: tb/tb_mul8_share_arb.sv
// Directed bench for mul8_share_arb: exact stub multiplier that returns
// 0x0006 for zero operands, so zero forcing is observable.
module tb_mul8_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mul_a, mul_b, mul_a0, mul_b0;
    logic [15:0] mul_o, mul_o0;
    logic [15:0] op_count, op_count0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mul8_share_arb_if #(.NREQ(4), .IDW(2)) bus ();
    mul8_share_arb_if #(.NREQ(4), .IDW(2)) bus0 ();

    assign mul_o  = (mul_a == 8'h00 || mul_b == 8'h00) ? 16'h0006 : {8'h00, mul_a} * {8'h00, mul_b};
    assign mul_o0 = (mul_a0 == 8'h00 || mul_b0 == 8'h00) ? 16'h0006 : {8'h00, mul_a0} * {8'h00, mul_b0};

    mul8_share_arb #(.NREQ(4), .IDW(2), .ZERO_FORCE(1), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .op_count(op_count)
    );

    mul8_share_arb #(.NREQ(4), .IDW(2), .ZERO_FORCE(0), .CNTW(16)) dut_nz (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_o(mul_o0), .op_count(op_count0)
    );

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[i]   = v;
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111; bus.req_a = 32'h0102_0304; bus.req_b = 32'h0506_0708;
        bus.rsp_ready = 1'b1;
        bus0.req_valid = 4'b0000; bus0.req_a = 32'h0; bus0.req_b = 32'h0; bus0.rsp_ready = 1'b1;
        #3;
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_id !== 2'd0 || bus.rsp_prod !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp: got id %0d prod %h want 0/0000", bus.rsp_id, bus.rsp_prod); end
        vectors++; if (mul_a !== 8'h00 || mul_b !== 8'h00) begin miscompares++; $display("FAIL reset_mul: got %h/%h want 00/00", mul_a, mul_b); end
        vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", op_count); end
        step();
        step();
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    // Operands per requester: 3x5=15, 19x6=114, 35x7=245, 51x8=408
    task automatic test_fairness();
        logic [7:0]  a_t [4] = '{8'd3, 8'd19, 8'd35, 8'd51};
        logic [7:0]  b_t [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
        logic [15:0] p_t [4] = '{16'd15, 16'd114, 16'd245, 16'd408};
        int          order [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0]  exp_ready;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, a_t[i], b_t[i]);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) bus.req_valid = 4'b0000;
            @(negedge clk);
            if (c < 6) begin
                exp_ready = 4'b0001 << order[c];
                vectors++; if (bus.req_ready !== exp_ready) begin miscompares++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            end
            if (c >= 2) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(order[c-2]) || bus.rsp_prod !== p_t[order[c-2]]) begin
                    miscompares++;
                    $display("FAIL rr_rsp c%0d: got v%b id%0d %0d want v1 id%0d %0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, order[c-2], p_t[order[c-2]]);
                end
            end else begin
                vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rr_early c%0d: got rsp_valid %b want 0", c, bus.rsp_valid); end
            end
            step();
        end
        vectors++; if (bus.rsp_valid !== 1'b0 || op_count !== 16'd6) begin miscompares++; $display("FAIL rr_drain: got v%b count %0d want v0 count 6", bus.rsp_valid, op_count); end
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 8'd12, 8'd13);
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (mul_a !== 8'd12 || mul_b !== 8'd13 || op_count !== 16'd7 || bus.rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_s1: got a%0d b%0d count%0d v%b want a12 b13 count7 v0", mul_a, mul_b, op_count, bus.rsp_valid);
        end
        step();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_prod !== 16'd156) begin
            miscompares++; $display("FAIL single_rsp: got v%b id%0d %0d want v1 id0 156", bus.rsp_valid, bus.rsp_id, bus.rsp_prod);
        end
        step();
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_clear: got rsp_valid %b want 0", bus.rsp_valid); end
    endtask

    // Pointer sits at 1: requests 1 (200x100), 2 (17x3), 3 (128x2).
    task automatic test_backpressure();
        logic        rr_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  gr_t [9] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic        rv_t [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  id_t [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [15:0] pr_t [9] = '{16'd0, 16'd0, 16'd20000, 16'd20000, 16'd20000, 16'd20000, 16'd51, 16'd256, 16'd0};
        set_req(1, 1'b1, 8'd200, 8'd100);
        set_req(2, 1'b1, 8'd17, 8'd3);
        set_req(3, 1'b1, 8'd128, 8'd2);
        for (int c = 0; c < 9; c++) begin
            bus.rsp_ready = rr_t[c];
            @(negedge clk);
            vectors++; if (bus.req_ready !== gr_t[c]) begin miscompares++; $display("FAIL bp_ready c%0d: got %b want %b", c, bus.req_ready, gr_t[c]); end
            vectors++;
            if (bus.rsp_valid !== rv_t[c] || (rv_t[c] && (bus.rsp_id !== id_t[c] || bus.rsp_prod !== pr_t[c]))) begin
                miscompares++;
                $display("FAIL bp_rsp c%0d: got v%b id%0d %0d want v%b id%0d %0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, rv_t[c], id_t[c], pr_t[c]);
            end
            if (c == 3) begin
                vectors++; if (op_count !== 16'd9 || mul_a !== 8'd17) begin miscompares++; $display("FAIL bp_hold: got count%0d mul_a%0d want count9 mul_a17", op_count, mul_a); end
            end
            step();
            if (c == 0) bus.req_valid[1] = 1'b0;
            if (c == 1) bus.req_valid[2] = 1'b0;
            if (c == 5) bus.req_valid[3] = 1'b0;
        end
        vectors++; if (op_count !== 16'd10) begin miscompares++; $display("FAIL bp_count: got %0d want 10", op_count); end
    endtask

    task automatic test_zero_force();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'd0, 8'd200);
        bus0.req_valid = 4'b0001; bus0.req_a[7:0] = 8'd0; bus0.req_b[7:0] = 8'd200;
        step();
        bus.req_valid = 4'b0000; bus0.req_valid = 4'b0000;
        step();
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 16'h0000) begin miscompares++; $display("FAIL zf1_a0: got v%b %h want v1 0000", bus.rsp_valid, bus.rsp_prod); end
        vectors++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_prod !== 16'h0006) begin miscompares++; $display("FAIL zf0_a0: got v%b %h want v1 0006", bus0.rsp_valid, bus0.rsp_prod); end
        set_req(0, 1'b1, 8'd7, 8'd0);
        step();
        bus.req_valid = 4'b0000;
        step();
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 16'h0000) begin miscompares++; $display("FAIL zf1_b0: got v%b %h want v1 0000", bus.rsp_valid, bus.rsp_prod); end
        step();
    endtask

    task automatic test_max_operands();
        set_req(0, 1'b1, 8'hFF, 8'hFF);
        step();
        bus.req_valid = 4'b0000;
        vectors++; if (mul_a !== 8'hFF || mul_b !== 8'hFF || op_count !== 16'd13) begin miscompares++; $display("FAIL max_s1: got %h/%h count%0d want FF/FF count13", mul_a, mul_b, op_count); end
        step();
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 16'hFE01) begin miscompares++; $display("FAIL max_prod: got v%b %h want v1 FE01", bus.rsp_valid, bus.rsp_prod); end
        step();
    endtask

    // Pointer sits at 1: requests 2 and 3 fill both stages under backpressure.
    task automatic test_reset_midflight();
        bus.rsp_ready = 1'b0;
        set_req(2, 1'b1, 8'd9, 8'd9);
        set_req(3, 1'b1, 8'd10, 8'd10);
        step();
        bus.req_valid[2] = 1'b0;
        step();
        bus.req_valid[3] = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || mul_a !== 8'd10) begin miscompares++; $display("FAIL mid_full: got v%b id%0d mul_a%0d want v1 id2 mul_a10", bus.rsp_valid, bus.rsp_id, mul_a); end
        set_req(0, 1'b1, 8'd4, 8'd5);
        set_req(1, 1'b1, 8'd6, 8'd6);
        set_req(2, 1'b1, 8'd9, 8'd9);
        set_req(3, 1'b1, 8'd10, 8'd10);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 1'b0 || mul_a !== 8'h00 || mul_b !== 8'h00) begin miscompares++; $display("FAIL mid_async: got v%b %h/%h want v0 00/00", bus.rsp_valid, mul_a, mul_b); end
        vectors++; if (op_count !== 16'd0 || bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_async_cnt: got count%0d ready %b want 0/0000", op_count, bus.req_ready); end
        step();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0001 || op_count !== 16'd0) begin miscompares++; $display("FAIL mid_regrant: got ready %b count%0d want 0001 count0", bus.req_ready, op_count); end
        step();
        bus.req_valid = 4'b0000;
        vectors++; if (op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale: got count%0d v%b want count1 v0", op_count, bus.rsp_valid); end
        step();
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_prod !== 16'd20) begin miscompares++; $display("FAIL mid_rsp: got v%b id%0d %0d want v1 id0 20", bus.rsp_valid, bus.rsp_id, bus.rsp_prod); end
        step();
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_end: got rsp_valid %b want 0", bus.rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_zero_force();
        test_max_operands();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mul8_share_arb.md
Name: mul8_share_arb

Overview:
- Round-robin scheduler that time-shares one combinational approximate 8x8 multiplier instance (any mul8_* netlist) among NREQ requesters.
- Accepts operand pairs over valid/ready channels, registers them onto the multiplier inputs, captures the 16-bit product, and returns it with the requester ID on one shared response channel.
- Optionally forces exact zero results for zero operands, because approximate netlists can produce nonzero output for zero inputs.
- Sits between the accelerator's operand sources and the multiplier instance, which is wired outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
ZERO_FORCE, 1, if 1, response product is 0 whenever either operand is 0
CNTW, 16, width of the accepted-operation counter

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester operand valid
req_a  in  8*NREQ  operand A, requester i in bits [8i+7:8i]
req_b  in  8*NREQ  operand B, same packing
req_ready  out  NREQ  one-hot grant/accept; at most one bit high
mul_a  out  8  registered operand A to multiplier instance
mul_b  out  8  registered operand B to multiplier instance
mul_o  in  16  multiplier product (combinational from mul_a/mul_b)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  requester index of the response
rsp_prod  out  16  product
op_count  out  CNTW  number of accepted requests; wraps at 2**CNTW

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_prod=0, op_count=0. Internal: stage-1 valid=0, RR pointer=0, zero flag=0. req_ready is combinational and is 0 while rst_n=0.
- Pipeline stages:
  - S1 holds op_a, op_b, id, s1_valid and the zero flag. mul_a/mul_b are driven directly from the S1 registers.
  - S2 is the response register: rsp_valid, rsp_id, rsp_prod.
- Stall rule: s2_free = !rsp_valid | rsp_ready; s1_free = !s1_valid | s2_free.
- Arbitration (combinational, per cycle):
  - If s1_free, grant the first i with req_valid[i]=1, searching from the pointer upward, modulo NREQ. req_ready[i] is high only for that i.
  - If !s1_free, req_ready is all zero.
- Accept is req_valid[i] & req_ready[i]. On the edge:
  - S1 loads req_a[i], req_b[i], id=i, zero flag=(a==0 | b==0).
  - Pointer becomes (i+1) mod NREQ.
  - op_count increments.
  - Pointer is unchanged when nothing is accepted.
- S1 to S2: if s1_valid and s2_free, S2 loads rsp_prod=(ZERO_FORCE & zero flag) ? 0 : mul_o, plus rsp_id. rsp_valid is set.
- S1 clears at that same edge unless a new accept refills it.
- Response handshake: if s2_free and S1 is not valid, rsp_valid clears. When rsp_valid=1 and rsp_ready=0, rsp_id and rsp_prod hold stable.
- Latency: accept at edge k gives rsp_valid=1 after edge k+1 (2 cycles), provided there is no backpressure.
- Throughput: one operation per cycle with rsp_ready tied high.
- Requester rules: a requester must hold req_valid and its operands stable until accepted. Dropping valid before acceptance is permitted, and no state changes.
- Full backpressure: S2 full with rsp_ready=0 and S1 full means no accept; both stages hold with exactly 2 operations in flight.
- Simultaneous pop and push: rsp_ready=1 with S1 valid and a new request in the same cycle moves all three positions in one edge, with no bubble.
- Single requester: the same requester wins every cycle; the pointer still advances, but fairness applies only among active requesters.
- Operand values: operands 0xFF x 0xFF pass through unaltered. The product width is exactly 16; no truncation is applied by this block.
- Reset mid-operation: all in-flight operations are discarded and no response is emitted for them. Outputs return to reset values asynchronously.

Test Plan:
- Bench uses an exact stub mul_o=mul_a*mul_b. Single request: req_valid=0001, a=12, b=13, rsp_ready=1 → req_ready=0001 in that cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_prod=156; op_count=1.
- Fairness: all 4 valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1; one response per cycle; rsp_id follows the same order.
- Backpressure: 3 back-to-back requests, rsp_ready=0 for 5 cycles → exactly 2 accepted, req_ready=0 thereafter; rsp_prod stable. Release gives the 3 responses in order with no loss or duplication.
- Zero force: a=0, b=200, with the stub replaced by one returning 0x0006 for zero inputs → ZERO_FORCE=1 gives rsp_prod=0; ZERO_FORCE=0 gives rsp_prod=0x0006.
- Max operands: a=255, b=255 → rsp_prod=65025 (0xFE01).
- Reset mid-flight: assert rst_n=0 while both stages are full → rsp_valid=0 and mul_a/mul_b=0 immediately. After release, the first grant goes to requester 0 and op_count=0.
